count_wrap_display: RTL and testbench



---
 rtl/count_wrap_display.sv | 134 +++++++++++++
 tb/tb_count_wrap_display.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_wrap_display.sv
// Counts F->0 wraps of a 4-bit counter into a saturating 2-digit BCD count and scans the result onto a 4-digit 7-segment display.
// Optional build macro WRAP_DISP_SYNC_EN selects a two-flop synchronizer on q_in; otherwise a single sample register is used.
module count_wrap_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] q_in,
  input  logic       clr,
  output logic       wrap_pulse,
  output logic [7:0] wrap_count,
  output logic       sat,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  logic [3:0]  s2;
  logic [3:0]  prev;
  logic        wrap_det;
  logic [15:0] presc;
  logic [1:0]  idx;
  logic [1:0]  idx_nxt;
  logic        presc_term;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'ha: r = 7'h08;
      4'hb: r = 7'h03;
      4'hc: r = 7'h46;
      4'hd: r = 7'h21;
      4'he: r = 7'h06;
      default: r = 7'h0e;
    endcase
    return r;
  endfunction

`ifdef WRAP_DISP_SYNC_EN
  logic [3:0] s1;

  // q_in may come from a ripple clock domain, so it is resynchronized before use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 4'h0;
      s2 <= 4'h0;
    end else begin
      s1 <= q_in;
      s2 <= s1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s2 <= 4'h0;
    else      s2 <= q_in;
  end
`endif

  // wrap_pulse is a valid-only strobe: one cycle per wrap, no ready/backpressure;
  // wrap_count and sat are already updated in the cycle the strobe is high.
  assign wrap_det = (prev == 4'hf) && (s2 == 4'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev       <= 4'h0;
      wrap_pulse <= 1'b0;
    end else begin
      prev       <= s2;
      wrap_pulse <= wrap_det;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_count <= 8'h00;
      sat        <= 1'b0;
    end else if (clr) begin
      wrap_count <= 8'h00;
      sat        <= 1'b0;
    end else if (wrap_det && !sat) begin
      if (wrap_count[3:0] == 4'd9) begin
        wrap_count[3:0] <= 4'd0;
        wrap_count[7:4] <= wrap_count[7:4] + 4'd1;
      end else begin
        wrap_count[3:0] <= wrap_count[3:0] + 4'd1;
      end
      sat <= (wrap_count == 8'h98);
    end
  end

  assign presc_term = (presc == PRESC_LAST);
  assign idx_nxt    = presc_term ? idx + 2'd1 : idx;

  // seg is refreshed every cycle from the digit that will be active after this edge,
  // so the display follows s2/wrap_count with one cycle of lag.
  always_comb begin
    an_nxt  = ~(4'b0001 << idx_nxt);
    seg_nxt = 7'h7f;
    case (idx_nxt)
      2'd0: seg_nxt = hex7(s2);
      2'd1: seg_nxt = hex7(wrap_count[3:0]);
      2'd2: seg_nxt = hex7(wrap_count[7:4]);
      default: seg_nxt = sat ? 7'h06 : 7'h7f;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= 16'd0;
      idx   <= 2'd0;
      an    <= 4'b1110;
      seg   <= 7'h40;
    end else begin
      presc <= presc_term ? 16'd0 : presc + 16'd1;
      idx   <= idx_nxt;
      an    <= an_nxt;
      seg   <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_count_wrap_display.sv
// Bench for count_wrap_display: randomized q_in/clr stimulus, an edge-tagged wrap scoreboard and display scan checks.
module tb_count_wrap_display;

`ifdef WRAP_DISP_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] q_in = 4'h0;
  logic       clr = 1'b0;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic       sat;
  logic [3:0] an;
  logic [6:0] seg;

  count_wrap_display #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .clr(clr),
    .wrap_pulse(wrap_pulse), .wrap_count(wrap_count), .sat(sat),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int errors = 0;
  int checks = 0;

  // Reference model: wrap count as a plain integer and the history of q_in seen at each edge.
  logic [8:0] exp_q[$];
  int         exp_edge[$];
  logic [3:0] hist[$];
  int         m_count = 0;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
    return t[v];
  endfunction

  function automatic logic [7:0] bcd(input int c);
    return {4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic model_reset();
    m_count = 0;
    exp_q.delete();
    exp_edge.delete();
    hist.delete();
    repeat (4) hist.push_back(4'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge of stimulus; the model decides whether this edge registers a wrap.
  task automatic step(input logic [3:0] qv, input logic cv);
    int  n;
    bit  due;
    @(negedge clk);
    q_in = qv;
    clr  = cv;
    hist.push_back(qv);
    if (hist.size() > 8) void'(hist.pop_front());
    n   = hist.size();
    due = (hist[n-2-LAT] == 4'hf) && (hist[n-1-LAT] == 4'h0);
    if (cv) m_count = 0;
    else if (due && m_count < 99) m_count++;
    if (due) begin
      exp_q.push_back({(m_count == 99) ? 1'b1 : 1'b0, bcd(m_count)});
      exp_edge.push_back(edge_n + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quick_wraps(input int k);
    for (int i = 0; i < k; i++) begin
      step(4'hf, 1'b0);
      step(4'h0, 1'b0);
    end
  endtask

  task automatic ramp_wrap();
    for (int v = 1; v <= 16; v++) begin
      int h;
      h = $urandom_range(1, 2);
      for (int j = 0; j < h; j++) step(4'(v), 1'b0);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [3:0] a, input logic [3:0] qv);
    logic [7:0] b;
    b = bcd(m_count);
    case (a)
      4'b1110: return hex7(qv);
      4'b1101: return hex7(b[3:0]);
      4'b1011: return hex7(b[7:4]);
      4'b0111: return (m_count == 99) ? 7'h06 : 7'h7f;
      default: return 7'h7f;
    endcase
  endfunction

  task automatic check_scan(input logic [3:0] qv, input int nc);
    logic [3:0] prev_an;
    int run;
    bit first;
    repeat (4) step(qv, 1'b0);
    prev_an = an;
    run = 1;
    first = 1;
    for (int i = 0; i < nc; i++) begin
      step(qv, 1'b0);
      chk("scan_seg", {25'd0, seg}, {25'd0, exp_seg(an, qv)});
      if (an !== prev_an) begin
        if (!first) chk("scan_dwell", run, DIV);
        chk("scan_order", {28'd0, an}, {28'd0, prev_an[2:0], prev_an[3]});
        first = 0;
        run = 1;
        prev_an = an;
      end else begin
        run++;
      end
    end
  endtask

  // Monitor: every strobe must match the head of the queue, on the expected edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (exp_edge.size() > 0 && exp_edge[0] == edge_n) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          void'(exp_edge.pop_front());
          checks++;
          if (wrap_pulse !== 1'b1 || {sat, wrap_count} !== e) begin
            errors++;
            $display("FAIL wrap_sb: pulse=%b sat=%b count=%h expected pulse=1 sat=%b count=%h",
                     wrap_pulse, sat, wrap_count, e[8], e[7:0]);
          end
        end else if (wrap_pulse === 1'b1) begin
          checks++;
          errors++;
          $display("FAIL wrap_spurious: pulse=1 at edge %0d expected 0", edge_n);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", {25'd0, seg}, 32'h40);
    chk("rst_an", {28'd0, an}, 32'he);
    chk("rst_count", {24'd0, wrap_count}, 32'h0);
    chk("rst_sat", {31'd0, sat}, 32'h0);
    chk("rst_pulse", {31'd0, wrap_pulse}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    hist.push_back(q_in);

    // first sample of 0 after reset, then a single ramp wrap and an F->3 jump
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);
    for (int v = 1; v <= 16; v++) begin
      step(4'(v), 1'b0);
      step(4'(v), 1'b0);
    end
    repeat (3) step(4'h0, 1'b0);
    chk("single_wrap", {24'd0, wrap_count}, 32'h01);
    step(4'hf, 1'b0);
    step(4'h3, 1'b0);
    step(4'h0, 1'b0);
    step(4'hf, 1'b0);
    repeat (4) step(4'h3, 1'b0);
    chk("no_wrap_jumps", {24'd0, wrap_count}, 32'h01);

    // scan content with count 12 and q_in 5
    step(4'h5, 1'b1);
    quick_wraps(12);
    check_scan(4'h5, 20);
    chk("scan_count", {24'd0, wrap_count}, 32'h12);

    // clear colliding with a wrap at count 08
    step(4'h1, 1'b1);
    quick_wraps(8);
    repeat (3) step(4'h1, 1'b0);
    chk("pre_clr_count", {24'd0, wrap_count}, 32'h08);
    step(4'hf, 1'b0);
    step(4'h0, 1'b0);
    for (int i = 1; i < LAT; i++) step(4'h0, 1'b0);
    step(4'h0, 1'b1);
    step(4'h0, 1'b0);
    chk("clr_collide", {24'd0, wrap_count}, 32'h00);

    // saturation
    step(4'h0, 1'b1);
    for (int i = 0; i < 100; i++) ramp_wrap();
    check_scan(4'h7, 16);
    chk("sat_count", {24'd0, wrap_count}, 32'h99);
    chk("sat_flag", {31'd0, sat}, 32'h1);
    step(4'h0, 1'b0);
    ramp_wrap();
    repeat (4) step(4'h2, 1'b0);
    chk("sat_hold", {24'd0, wrap_count}, 32'h99);

    // randomized stretch with occasional clears
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [3:0] qv;
      r = $urandom_range(0, 9);
      qv = (r < 3) ? 4'hf : (r < 6) ? 4'h0 : 4'($urandom_range(0, 15));
      step(qv, ($urandom_range(0, 39) == 0));
    end
    repeat (4) step(4'h4, 1'b0);
    chk("rand_count", {24'd0, wrap_count}, {24'd0, bcd(m_count)});
    check_scan(4'h4, 12);

    // reset mid-scan at count 37 while digit 2 is shown
    step(4'h9, 1'b1);
    quick_wraps(37);
    repeat (3) step(4'h9, 1'b0);
    chk("pre_rst_count", {24'd0, wrap_count}, 32'h37);
    begin
      int k;
      k = 0;
      while (an !== 4'b1011 && k < 40) begin
        step(4'h9, 1'b0);
        k++;
      end
      chk("wait_an_1011", {28'd0, an}, 32'hb);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_an", {28'd0, an}, 32'he);
    chk("mid_rst_seg", {25'd0, seg}, 32'h40);
    chk("mid_rst_count", {24'd0, wrap_count}, 32'h0);
    chk("mid_rst_sat", {31'd0, sat}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    hist.push_back(q_in);
    check_scan(4'h9, 20);
    ramp_wrap();
    repeat (4) step(4'h1, 1'b0);
    chk("post_rst_wrap", {24'd0, wrap_count}, 32'h01);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
